line_xfer_master: RTL and testbench
===================================

# line_xfer_master

Memory-side transfer engine that sits between a cache controller and the word-wide main memory (`mem`: one-cycle registered read, write on clock edge). It moves whole cache lines: a writeback copies a dirty line buffer into memory, a fill reads a line from memory into a line buffer, and a combined request does the writeback and then the fill. It is the initiator on the memory's `addr` / `wr_req` / `wr_data` / `rd_data` interface.

## Interface
- `ADDR_LEN`, 11: word-address width of main memory.
- `LINE_ADDR_LEN`, 3: log2 of words per line; `LINE_SIZE = 1<<LINE_ADDR_LEN`, default 8.
- `TAG_LEN` (derived): `ADDR_LEN-LINE_ADDR_LEN`.

- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  1  start request; sampled only in IDLE.
- `req_wb`  in  1  perform writeback of `wb_data` to `wb_line`.
- `req_fill`  in  1  perform fill from `fill_line`.
- `wb_line`  in  TAG_LEN  line number for writeback.
- `fill_line`  in  TAG_LEN  line number for fill.
- `wb_data`  in  32*LINE_SIZE  line to write; word k at bits [32k+31:32k].
- `fill_data`  out  32*LINE_SIZE  filled line, same packing.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDR_LEN  memory word address.
- `mem_wr_req`  out  1  memory write strobe.
- `mem_wr_data`  out  32  memory write data.
- `mem_rd_data`  in  32  memory read data, valid one cycle after its address.

## Operation
- States: IDLE, WB, FILL, DRAIN. Word counter `cnt`, LINE_ADDR_LEN bits.
- IDLE accept: an edge with `req=1` and (`req_wb` or `req_fill`) latches `wb_line`, `fill_line`, `wb_data`, and a pending-fill flag, and clears `cnt`. The next state is WB if `req_wb`, otherwise FILL. A request with both flags low is ignored and produces no `done`.
- `req` during non-IDLE states is ignored; there is no queueing.
- WB, LINE_SIZE cycles:
  - `mem_wr_req=1`, `mem_addr={wb_line,cnt}`, `mem_wr_data`= latched word `cnt`.
  - At `cnt=LINE_SIZE-1`: go to FILL with `cnt` cleared if fill is pending; otherwise go to IDLE and pulse `done`.
- FILL, LINE_SIZE cycles:
  - `mem_wr_req=0`, `mem_addr={fill_line,cnt}`.
  - Each cycle with `cnt>0` captures `mem_rd_data` into word `cnt-1`.
  - After `cnt=LINE_SIZE-1`, go to DRAIN.
- DRAIN, 1 cycle: captures word LINE_SIZE-1, then goes to IDLE and pulses `done`.
- `fill_data` is updated only by captures, so it holds its last value between fills. A writeback-only operation leaves it untouched.
- IDLE and DRAIN: `mem_wr_req=0`, `mem_addr=0`, `mem_wr_data=0`.
- Memory outputs are decoded from the state and counter registers only. There is no combinational path from `req` or any other input to the memory ports.
- Counter wraps naturally; state transitions are keyed on `cnt=LINE_SIZE-1`.
- Combined writeback+fill to the same line returns the just-written data: the last write commits at the edge ending WB, before the first fill read.

## Timing
- Reset values: state IDLE, `cnt=0`, `busy=0`, `done=0`, `mem_wr_req=0`, `mem_addr=0`, `mem_wr_data=0`, `fill_data=0`, latches 0.
- Reset mid-operation aborts in the next cycle: `mem_wr_req=0`, no `done`. Words already written stay in memory; `fill_data` is cleared.
- Take cycle 0 as the cycle in which `req` is sampled in IDLE. Then:
  - Writeback only: WB in cycles 1..N; `done=1` in cycle N+1 (9 for N=8).
  - Fill only: FILL in cycles 1..N, DRAIN in cycle N+1; `done` and final `fill_data` in cycle N+2 (10).
  - Both: WB in 1..N, FILL in N+1..2N, DRAIN in 2N+1; `done` in cycle 2N+2 (18).
- `busy` is high exactly in WB/FILL/DRAIN cycles and is low in the `done` cycle.
- A new `req` can be accepted in the `done` cycle, giving back-to-back operations with no idle gap.
- `done` is registered and lasts exactly one cycle.

## Test plan
- Fill only: preload memory words 0x40..0x47 with 0xA0+i, `req_fill=1`, `fill_line=8` ->
  - `done` in cycle 10;
  - `fill_data` word i = 0xA0+i;
  - `mem_wr_req` never high.
- Writeback only: `wb_line=3`, word i = 0x1000+i ->
  - `mem_addr` 0x18..0x1F in cycles 1..8 with `mem_wr_req=1`;
  - memory holds 0x1000+i afterwards;
  - `done` in cycle 9;
  - `fill_data` unchanged.
- Combined, same line: `wb_line=fill_line=5`, data 0xBEEF0000+i ->
  - `done` in cycle 18;
  - `fill_data` word i = 0xBEEF0000+i.
- Ignored requests:
  - `req` pulsed in cycles 3 and 5 of a fill -> no effect; exactly one `done`.
  - `req=1` with both flags 0 in IDLE -> `busy` stays 0; no `done`.
- Back-to-back: a new fill is issued in the `done` cycle of a writeback -> `busy` is high the next cycle and `done` comes 10 cycles after acceptance.
- Reset mid-writeback: `rst` in cycle 4 ->
  - from cycle 5: `mem_wr_req=0`, `busy=0`, `fill_data=0`;
  - only words 0..2 are written;
  - no `done`.

Source files
------------

// File: rtl/line_xfer_master.sv
// line_xfer_master: copies whole cache lines between line buffers and word-wide main memory.
// Latency: writeback done at N+1, fill at N+2, writeback+fill at 2N+2 cycles after req is sampled.
// Backpressure: one operation at a time; req is sampled only in IDLE and ignored while busy.
module line_xfer_master #(
   parameter  int ADDR_LEN      = 11,
   parameter  int LINE_ADDR_LEN = 3,
   localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN,
   localparam int TAG_LEN       = ADDR_LEN - LINE_ADDR_LEN
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_req,
   input  logic                      i_req_wb,
   input  logic                      i_req_fill,
   input  logic [TAG_LEN-1:0]        i_wb_line,
   input  logic [TAG_LEN-1:0]        i_fill_line,
   input  logic [32*LINE_SIZE-1:0]   i_wb_data,
   output logic [32*LINE_SIZE-1:0]   o_fill_data,
   output logic                      o_busy,
   output logic                      o_done,
   output logic [ADDR_LEN-1:0]       o_mem_addr,
   output logic                      o_mem_wr_req,
   output logic [31:0]               o_mem_wr_data,
   input  logic [31:0]               i_mem_rd_data
);

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DRAIN} state_t;

   localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;
   localparam logic [LINE_ADDR_LEN-1:0] CNT_ONE  = LINE_ADDR_LEN'(1);

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [LINE_ADDR_LEN-1:0]   r_cnt;
   logic [LINE_ADDR_LEN-1:0]   w_cap_idx;
   logic                       r_done;
   logic                       w_done_nxt;
   logic                       w_accept;
   logic                       w_capture;
   logic                       r_fill_pend;
   logic [TAG_LEN-1:0]         r_wb_line;
   logic [TAG_LEN-1:0]         r_fill_line;
   logic [LINE_SIZE-1:0][31:0] r_wb_data;
   logic [LINE_SIZE-1:0][31:0] r_fill_data;

   // A request with neither flag set is not an operation and is dropped.
   assign w_accept  = (r_state == S_IDLE) && i_req && (i_req_wb || i_req_fill);
   // Read data lags its address by one cycle, so each capture lands in word cnt-1;
   // in DRAIN the counter has wrapped to 0, so cnt-1 is the last word.
   assign w_cap_idx = r_cnt - CNT_ONE;
   assign w_capture = ((r_state == S_FILL) && (r_cnt != '0)) || (r_state == S_DRAIN);

   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = r_done;
   assign o_fill_data = r_fill_data;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and completion decode, keyed on the last word of each phase.
   always_comb begin
      w_state_nxt = r_state;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = i_req_wb ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            if (r_cnt == CNT_LAST) begin
               if (r_fill_pend) begin
                  w_state_nxt = S_FILL;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         S_FILL: begin
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Memory port decode from state and counter only, so no input reaches memory combinationally.
   always_comb begin
      o_mem_wr_req  = 1'b0;
      o_mem_addr    = '0;
      o_mem_wr_data = '0;
      case (r_state)
         S_WB: begin
            o_mem_wr_req  = 1'b1;
            o_mem_addr    = {r_wb_line, r_cnt};
            o_mem_wr_data = r_wb_data[r_cnt];
         end
         S_FILL: begin
            o_mem_addr = {r_fill_line, r_cnt};
         end
         default: begin
         end
      endcase
   end

   // Request latches, word counter, done pulse and fill-line capture.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_fill_pend <= 1'b0;
         r_wb_line   <= '0;
         r_fill_line <= '0;
         r_wb_data   <= '0;
         r_fill_data <= '0;
      end else begin
         r_done <= w_done_nxt;
         if (w_accept) begin
            r_cnt       <= '0;
            r_fill_pend <= i_req_fill;
            r_wb_line   <= i_wb_line;
            r_fill_line <= i_fill_line;
            r_wb_data   <= i_wb_data;
         end else if ((r_state == S_WB) || (r_state == S_FILL)) begin
            // Wraps to 0 on the last word, which is the start value of the next phase.
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (w_capture) begin
            r_fill_data[w_cap_idx] <= i_mem_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_line_xfer_master.sv
// Bench for line_xfer_master: table of line operations plus hand-written corner sequences.
// Owns a word memory model (writes are held off while reset is asserted) and a shadow copy of it.
// Completions are checked against a queue of expected fill lines and done latencies.
module tb_line_xfer_master;
   localparam int ADDR_LEN = 11;
   localparam int LAL      = 3;
   localparam int N        = 1 << LAL;
   localparam int TAG      = ADDR_LEN - LAL;

   logic                clk = 1'b0;
   logic                rst;
   logic                req, req_wb, req_fill;
   logic [TAG-1:0]      wb_line, fill_line;
   logic [32*N-1:0]     wb_data, fill_data;
   logic                busy, done, mem_wr_req;
   logic [ADDR_LEN-1:0] mem_addr;
   logic [31:0]         mem_wr_data, mem_rd_data;

   logic                pre_we;
   logic [ADDR_LEN-1:0] pre_addr;
   logic [31:0]         pre_data;
   logic [31:0]         mem     [0:(1<<ADDR_LEN)-1];
   logic [31:0]         exp_mem [0:(1<<ADDR_LEN)-1];
   logic [32*N-1:0]     exp_fill;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [32*N-1:0] fill;
      int              cyc;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      bit           wb;
      bit           fill;
      logic [TAG-1:0] wbl;
      logic [TAG-1:0] fl;
      logic [31:0]  wbase;
      bit           pre;
      logic [31:0]  pbase;
      int           exp_done;
   } vec_t;
   vec_t vt[4];

   always #5 clk = ~clk;

   // Main memory: registered read, write on the edge; bench preload port has priority.
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_addr] <= pre_data;
      else if (mem_wr_req && !rst)
         mem[mem_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_addr];
   end

   line_xfer_master #(.ADDR_LEN(ADDR_LEN), .LINE_ADDR_LEN(LAL)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_wb(req_wb), .i_req_fill(req_fill),
      .i_wb_line(wb_line), .i_fill_line(fill_line), .i_wb_data(wb_data),
      .o_fill_data(fill_data), .o_busy(busy), .o_done(done), .o_mem_addr(mem_addr),
      .o_mem_wr_req(mem_wr_req), .o_mem_wr_data(mem_wr_data), .i_mem_rd_data(mem_rd_data)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event did not occur within its cycle budget", name);
   endtask

   task automatic preload(input logic [TAG-1:0] line, input logic [31:0] base);
      for (int i = 0; i < N; i++) begin
         pre_we   = 1'b1;
         pre_addr = {line, LAL'(i)};
         pre_data = base + 32'(i);
         exp_mem[{line, LAL'(i)}] = base + 32'(i);
         step();
      end
      pre_we = 1'b0;
   endtask

   task automatic set_inputs(input bit w, input bit f, input logic [TAG-1:0] wl,
                             input logic [TAG-1:0] fl, input logic [31:0] base);
      req      = 1'b1;
      req_wb   = w;
      req_fill = f;
      wb_line  = wl;
      fill_line = fl;
      for (int i = 0; i < N; i++) wb_data[32*i +: 32] = base + 32'(i);
   endtask

   // Drive a request in the current cycle and queue its expected completion.
   task automatic drive_req(input bit w, input bit f, input logic [TAG-1:0] wl,
                            input logic [TAG-1:0] fl, input logic [31:0] base, input int cyc);
      sb_t e;
      set_inputs(w, f, wl, fl, base);
      if (w) for (int i = 0; i < N; i++) exp_mem[{wl, LAL'(i)}] = base + 32'(i);
      if (f) for (int i = 0; i < N; i++) exp_fill[32*i +: 32] = exp_mem[{fl, LAL'(i)}];
      e.fill = exp_fill;
      e.cyc  = cyc;
      sbq.push_back(e);
   endtask

   task automatic sb_check(input string tag, input int cyc_rel);
      sb_t e;
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_unexpected_done: got done at cycle %0d, required none", tag, cyc_rel);
      end else begin
         e = sbq.pop_front();
         chk({tag, "_done_cyc"}, 256'(cyc_rel), 256'(e.cyc));
         chk({tag, "_fill"}, fill_data, e.fill);
      end
   endtask

   task automatic watch(input vec_t v, input string tag);
      bit got = 1'b0;
      int off = v.wb ? N : 0;
      for (int c = 1; c <= 30 && !got; c++) begin
         step();
         req = 1'b0;
         chk({tag, "_busy"}, busy, (c < v.exp_done));
         chk({tag, "_wr"}, mem_wr_req, (v.wb && c <= N));
         if (v.wb && c <= N) begin
            chk({tag, "_wr_addr"}, mem_addr, {v.wbl, LAL'(c-1)});
            chk({tag, "_wr_data"}, mem_wr_data, v.wbase + 32'(c-1));
         end
         if (v.fill && c > off && c <= off + N)
            chk({tag, "_rd_addr"}, mem_addr, {v.fl, LAL'(c-off-1)});
         if (done) begin
            sb_check(tag, c);
            got = 1'b1;
         end
      end
      if (!got) fail_now({tag, "_timeout"});
   endtask

   initial begin
      int nd;
      int acc;
      rst = 1'b1; req = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
      wb_line = '0; fill_line = '0; wb_data = '0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      exp_fill = '0;

      vt[0] = '{1'b0, 1'b1, TAG'(0),     TAG'(8), 32'h0,        1'b1, 32'hA0,       10};
      vt[1] = '{1'b1, 1'b0, TAG'(3),     TAG'(0), 32'h1000,     1'b0, 32'h0,        9};
      vt[2] = '{1'b1, 1'b1, TAG'(5),     TAG'(5), 32'hBEEF0000, 1'b1, 32'h55550000, 18};
      vt[3] = '{1'b1, 1'b1, TAG'(8'h10), TAG'(8), 32'hC0DE0000, 1'b0, 32'h0,        18};

      step(); step(); step();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wr_req", mem_wr_req, 1'b0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_wr_data", mem_wr_data, '0);
      chk("rst_fill", fill_data, '0);
      rst = 1'b0;
      step();

      // Table-driven line operations.
      for (int k = 0; k < 4; k++) begin
         string tag;
         tag = $sformatf("vec%0d", k);
         if (vt[k].pre) preload(vt[k].fl, vt[k].pbase);
         drive_req(vt[k].wb, vt[k].fill, vt[k].wbl, vt[k].fl, vt[k].wbase, vt[k].exp_done);
         watch(vt[k], tag);
         step();
         if (vt[k].wb)
            for (int i = 0; i < N; i++)
               chk($sformatf("%s_mem%0d", tag, i), mem[{vt[k].wbl, LAL'(i)}],
                   exp_mem[{vt[k].wbl, LAL'(i)}]);
      end

      // req pulses during a fill are ignored.
      drive_req(1'b0, 1'b1, '0, TAG'(8), 32'h0, 10);
      nd = 0;
      for (int c = 1; c <= 25; c++) begin
         step();
         if (c == 3 || c == 5) set_inputs(1'b1, 1'b1, TAG'(1), TAG'(2), 32'h77770000);
         else req = 1'b0;
         chk("ign_wr", mem_wr_req, 1'b0);
         if (done) begin
            nd++;
            sb_check("ign", c);
         end
      end
      chk("ign_ndone", 256'(nd), 256'(1));

      // Request with neither flag set is dropped.
      set_inputs(1'b0, 1'b0, TAG'(4), TAG'(4), 32'h0);
      nd = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         req = 1'b0;
         chk("noflag_busy", busy, 1'b0);
         if (done) nd++;
      end
      chk("noflag_ndone", 256'(nd), 256'(0));

      // Back-to-back: fill issued in the done cycle of a writeback.
      drive_req(1'b1, 1'b0, TAG'(2), '0, 32'h2000, 9);
      nd = 0;
      acc = 0;
      for (int c = 1; c <= 40 && nd < 2; c++) begin
         step();
         req = 1'b0;
         if (nd == 1 && c == acc + 1) chk("b2b_busy", busy, 1'b1);
         if (done) begin
            sb_check("b2b", c - acc);
            nd++;
            if (nd == 1) begin
               drive_req(1'b0, 1'b1, '0, TAG'(2), 32'h0, 10);
               acc = c;
            end
         end
      end
      if (nd != 2) fail_now("b2b_timeout");
      step();

      // Reset in cycle 4 of a writeback.
      preload(TAG'(6), 32'hDEAD0000);
      set_inputs(1'b1, 1'b0, TAG'(6), '0, 32'h6000);
      for (int i = 0; i < 3; i++) exp_mem[{TAG'(6), LAL'(i)}] = 32'h6000 + 32'(i);
      for (int c = 1; c <= 4; c++) begin
         step();
         req = 1'b0;
         if (c == 4) rst = 1'b1;
      end
      step();
      rst = 1'b0;
      exp_fill = '0;
      chk("rstmid_wr", mem_wr_req, 1'b0);
      chk("rstmid_busy", busy, 1'b0);
      chk("rstmid_fill", fill_data, exp_fill);
      nd = 0;
      for (int c = 6; c <= 20; c++) begin
         step();
         if (done) nd++;
      end
      chk("rstmid_ndone", 256'(nd), 256'(0));
      for (int i = 0; i < N; i++)
         chk($sformatf("rstmid_mem%0d", i), mem[{TAG'(6), LAL'(i)}], exp_mem[{TAG'(6), LAL'(i)}]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
